control_puertas_n: RTL and testbench

- Parametrised N-floor elevator door controller; successor to the fixed 4-floor door block.
- Owns the door state machine, door-travel timer and open-hold timer internally; no external door-state or timeout inputs.
- Adds request-clear pulses, reopen counting with a forced-close (nudge) mode, and an arbitrary floor count.
- Sits between the floor-request logic and the door motor driver; handshakes with the movement controller via moviendo/trabajando.

---
 rtl/control_puertas_n.sv | 167 ++++++++++++++++
 tb/tb_control_puertas_n.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_puertas_n.sv
// Door controller for an N-floor elevator. It runs the door state machine and its travel and
// open-hold timers, and produces the chime, request-clear and forced-close (nudge) outputs.
module control_puertas_n #(
  parameter int N_PISOS         = 4,
  parameter int PISO_W          = 2,
  parameter int T_MOVER         = 8,
  parameter int T_ABIERTA       = 50,
  parameter int MAX_REAPERTURAS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PISO_W-1:0]   piso_actual,
  input  logic                moviendo,
  input  logic                subiendo,
  input  logic [N_PISOS-1:0]  sol_cabina,
  input  logic [N_PISOS-1:0]  sol_subir,
  input  logic [N_PISOS-1:0]  sol_bajar,
  input  logic [1:0]          boton,
  input  logic                sensor,
  output logic [1:0]          salida_puertas,
  output logic [1:0]          estado_puertas,
  output logic                trabajando,
  output logic [N_PISOS-1:0]  aviso,
  output logic [N_PISOS-1:0]  limpiar_cabina,
  output logic [N_PISOS-1:0]  limpiar_subir,
  output logic [N_PISOS-1:0]  limpiar_bajar,
  output logic                nudge
);

  localparam int T_MAX = (T_MOVER > T_ABIERTA) ? T_MOVER : T_ABIERTA;
  localparam int CNT_W = $clog2(T_MAX);
  localparam int REA_W = $clog2(MAX_REAPERTURAS + 1);
  localparam logic [CNT_W-1:0]   CNT_MOVER   = CNT_W'(T_MOVER - 1);
  localparam logic [CNT_W-1:0]   CNT_ABIERTA = CNT_W'(T_ABIERTA - 1);
  localparam logic [CNT_W-1:0]   CNT_UNO     = CNT_W'(1);
  localparam logic [REA_W-1:0]   REA_MAX     = REA_W'(MAX_REAPERTURAS);
  localparam logic [N_PISOS-1:0] PRIMERO     = N_PISOS'(1);
  localparam logic [N_PISOS-1:0] ULTIMO      = PRIMERO << (N_PISOS - 1);

  typedef enum logic [1:0] {
    CERRADA  = 2'b00,
    ABIERTA  = 2'b01,
    CERRANDO = 2'b10,
    ABRIENDO = 2'b11
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REA_W-1:0]   rea_q, rea_d;
  logic               nudge_q, nudge_d;
  logic [N_PISOS-1:0] aviso_q, aviso_d;
  logic [N_PISOS-1:0] lcab_q, lcab_d, lsub_q, lsub_d, lbaj_q, lbaj_d;
  logic [1:0]         salida_q, salida_d;
  logic               trab_q, trab_d;

  logic [N_PISOS-1:0] piso_oh;
  logic               solicitado, abrir_btn, cerrar_btn;

  // One-hot of the current floor; an out-of-range index yields all zeros and so is never requested.
  always_comb begin
    for (int p = 0; p < N_PISOS; p++) begin
      piso_oh[p] = (piso_actual == PISO_W'(p));
    end
  end

  assign solicitado = |(piso_oh & (sol_cabina
                                   | (subiendo ? sol_subir : sol_bajar)
                                   | (sol_subir & PRIMERO)
                                   | (sol_bajar & ULTIMO)));
  assign abrir_btn  = (boton == 2'b01);
  assign cerrar_btn = (boton == 2'b10);

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    rea_d    = rea_q;
    nudge_d  = nudge_q;
    aviso_d  = '0;
    lcab_d   = '0;
    lsub_d   = '0;
    lbaj_d   = '0;
    case (estado_q)
      CERRADA: begin
        if (!moviendo && (solicitado || abrir_btn)) begin
          estado_d = ABRIENDO;
          cnt_d    = CNT_MOVER;
          if (solicitado) aviso_d = piso_oh;
        end
      end
      ABRIENDO: begin
        if (cnt_q == '0) begin
          estado_d = ABIERTA;
          cnt_d    = CNT_ABIERTA;
          lcab_d   = piso_oh;
          lsub_d   = piso_oh & (subiendo ? '1 : PRIMERO);
          lbaj_d   = piso_oh & (!subiendo ? '1 : ULTIMO);
        end else begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      ABIERTA: begin
        if (!sensor && (cerrar_btn || cnt_q == '0)) begin
          estado_d = CERRANDO;
          cnt_d    = CNT_MOVER;
        end else if (sensor || abrir_btn || solicitado) begin
          cnt_d = CNT_ABIERTA;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      CERRANDO: begin
        // A reopen runs back over the distance already closed.
        if (!nudge_q && (sensor || abrir_btn || solicitado)) begin
          estado_d = ABRIENDO;
          cnt_d    = CNT_MOVER - cnt_q;
          rea_d    = rea_q + REA_W'(1);
          if (rea_d == REA_MAX) nudge_d = 1'b1;
        end else if (cnt_q == '0) begin
          estado_d = CERRADA;
          rea_d    = '0;
          nudge_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      default: estado_d = CERRADA;
    endcase
    salida_d = (estado_d == ABRIENDO) ? 2'b01 : (estado_d == CERRANDO) ? 2'b10 : 2'b00;
    trab_d   = (estado_d != CERRADA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= CERRADA;
      cnt_q    <= '0;
      rea_q    <= '0;
      nudge_q  <= 1'b0;
      aviso_q  <= '0;
      lcab_q   <= '0;
      lsub_q   <= '0;
      lbaj_q   <= '0;
      salida_q <= 2'b00;
      trab_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      rea_q    <= rea_d;
      nudge_q  <= nudge_d;
      aviso_q  <= aviso_d;
      lcab_q   <= lcab_d;
      lsub_q   <= lsub_d;
      lbaj_q   <= lbaj_d;
      salida_q <= salida_d;
      trab_q   <= trab_d;
    end
  end

  assign estado_puertas = estado_q;
  assign salida_puertas = salida_q;
  assign trabajando     = trab_q;
  assign aviso          = aviso_q;
  assign limpiar_cabina = lcab_q;
  assign limpiar_subir  = lsub_q;
  assign limpiar_bajar  = lbaj_q;
  assign nudge          = nudge_q;

endmodule

// File: tb/tb_control_puertas_n.sv
// Bench for control_puertas_n: a decision table from the closed state, hand-written door
// sequences, and random traffic scored against a cycle-level door model.
module tb_control_puertas_n;

  localparam int NP    = 4;
  localparam int PW    = 3;
  localparam int TM    = 4;
  localparam int TA    = 10;
  localparam int MAXR  = 2;
  localparam int EXP_W = 22;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [PW-1:0]  piso = '0;
  logic           moviendo = 1'b0, subiendo = 1'b0, sensor = 1'b0;
  logic [NP-1:0]  cab = '0, su = '0, ba = '0;
  logic [1:0]     boton = 2'b00;
  logic [1:0]     salida, estado;
  logic           trab, nudge;
  logic [NP-1:0]  aviso, lcab, lsub, lbaj;

  int checks = 0;
  int errors = 0;

  // Door model: phase 0 closed, 1 open, 2 closing, 3 opening; left = cycles remaining in phase.
  int m_mode, m_left, m_reopens;
  bit m_nudge;
  logic [EXP_W-1:0] exp_q[$];

  control_puertas_n #(
    .N_PISOS(NP), .PISO_W(PW), .T_MOVER(TM), .T_ABIERTA(TA), .MAX_REAPERTURAS(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .piso_actual(piso), .moviendo(moviendo), .subiendo(subiendo),
    .sol_cabina(cab), .sol_subir(su), .sol_bajar(ba), .boton(boton), .sensor(sensor),
    .salida_puertas(salida), .estado_puertas(estado), .trabajando(trab), .aviso(aviso),
    .limpiar_cabina(lcab), .limpiar_subir(lsub), .limpiar_bajar(lbaj), .nudge(nudge)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit req_at(int p);
    if (p >= NP) return 1'b0;
    return cab[p] || (subiendo && su[p]) || (!subiendo && ba[p]) ||
           (p == 0 && su[0]) || (p == NP - 1 && ba[NP-1]);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_reopens = 0; m_nudge = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit req = req_at(int'(piso));
    bit ob = (boton == 2'b01);
    bit cb = (boton == 2'b10);
    logic [NP-1:0] e_av = '0, e_lc = '0, e_ls = '0, e_lb = '0;
    logic [1:0] e_sal;
    case (m_mode)
      0: if (!moviendo && (req || ob)) begin
           m_mode = 3; m_left = TM;
           if (req) e_av[piso] = 1'b1;
         end
      3: if (m_left == 1) begin
           m_mode = 1; m_left = TA;
           for (int p = 0; p < NP; p++) begin
             if (p == int'(piso)) begin
               e_lc[p] = 1'b1;
               e_ls[p] = subiendo || p == 0;
               e_lb[p] = !subiendo || p == NP - 1;
             end
           end
         end else m_left--;
      1: if (!sensor && (cb || m_left == 1)) begin
           m_mode = 2; m_left = TM;
         end else if (sensor || ob || req) m_left = TA;
         else if (m_left > 1) m_left--;
      default: if (!m_nudge && (sensor || ob || req)) begin
           m_mode = 3; m_left = TM - m_left + 1;
           m_reopens++;
           if (m_reopens >= MAXR) m_nudge = 1'b1;
         end else if (m_left == 1) begin
           m_mode = 0; m_reopens = 0; m_nudge = 1'b0;
         end else m_left--;
    endcase
    e_sal = (m_mode == 3) ? 2'b01 : (m_mode == 2) ? 2'b10 : 2'b00;
    exp_q.push_back({2'(m_mode), e_sal, m_mode != 0, e_av, e_lc, e_ls, e_lb, m_nudge});
  endtask

  task automatic cmp_model();
    logic [EXP_W-1:0] e;
    e = exp_q.pop_front();
    chk("estado", estado, e[21:20]);
    chk("salida", salida, e[19:18]);
    chk("trabajando", trab, e[17]);
    chk("aviso", aviso, e[16:13]);
    chk("limpiar_cabina", lcab, e[12:9]);
    chk("limpiar_subir", lsub, e[8:5]);
    chk("limpiar_bajar", lbaj, e[4:1]);
    chk("nudge", nudge, e[0]);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #3;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    piso = '0; moviendo = 1'b0; subiendo = 1'b0; sensor = 1'b0;
    cab = '0; su = '0; ba = '0; boton = 2'b00;
  endtask

  // Steps while the door stays in state st, returning how many sampled cycles it was there.
  task automatic count_state(input logic [1:0] st, output int n);
    n = 0;
    while (estado == st && n < 100) begin
      n++;
      step();
    end
  endtask

  // Opens at floor 2 with an in-car call, then drops the call as floor logic would.
  task automatic open_at_2();
    piso = 3'd2; cab = 4'b0100;
    step();
    cab = '0;
  endtask

  typedef struct {
    logic [2:0] piso; logic mov; logic sub;
    logic [3:0] cab; logic [3:0] su; logic [3:0] ba; logic [1:0] bot;
    logic [1:0] e_estado; logic [3:0] e_aviso;
  } vec_t;

  vec_t tbl[12];
  int n;

  initial begin
    tbl[0]  = '{3'd2, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 2'b00, 2'b11, 4'b0100};
    tbl[1]  = '{3'd1, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 2'b00, 2'b00, 4'b0000};
    tbl[2]  = '{3'd1, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, 2'b00, 2'b11, 4'b0010};
    tbl[3]  = '{3'd2, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 2'b00, 2'b00, 4'b0000};
    tbl[4]  = '{3'd5, 1'b0, 1'b1, 4'b1111, 4'b1111, 4'b1111, 2'b00, 2'b00, 4'b0000};
    tbl[5]  = '{3'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 2'b00, 2'b11, 4'b0001};
    tbl[6]  = '{3'd3, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000, 2'b00, 2'b11, 4'b1000};
    tbl[7]  = '{3'd3, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0100, 2'b00, 2'b00, 4'b0000};
    tbl[8]  = '{3'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'b11, 4'b0000};
    tbl[9]  = '{3'd1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b11, 2'b00, 4'b0000};
    tbl[10] = '{3'd5, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'b11, 4'b0000};
    tbl[11] = '{3'd2, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0100, 2'b00, 2'b11, 4'b0100};

    // Reset state
    #1;
    chk("reset_estado", estado, 2'b00);
    chk("reset_salida", salida, 2'b00);
    chk("reset_trabajando", trab, 1'b0);
    chk("reset_nudge", nudge, 1'b0);
    @(posedge clk); #1;
    apply_reset();

    // Opening decisions from the closed door
    foreach (tbl[i]) begin
      apply_reset();
      piso = tbl[i].piso; moviendo = tbl[i].mov; subiendo = tbl[i].sub;
      cab = tbl[i].cab; su = tbl[i].su; ba = tbl[i].ba; boton = tbl[i].bot;
      step();
      chk($sformatf("tbl%0d_estado", i), estado, tbl[i].e_estado);
      chk($sformatf("tbl%0d_aviso", i), aviso, tbl[i].e_aviso);
      clear_inputs();
    end

    // Normal cycle at floor 2
    apply_reset();
    open_at_2();
    chk("n_aviso", aviso, 4'b0100);
    count_state(2'b11, n); chk("n_abriendo_cycles", n, TM);
    chk("n_limpiar_cabina", lcab, 4'b0100);
    count_state(2'b01, n); chk("n_abierta_cycles", n, TA);
    count_state(2'b10, n); chk("n_cerrando_cycles", n, TM);
    chk("n_trabajando_end", trab, 1'b0);

    // Direction filter: down travel ignores an up call at floor 1, up travel takes it
    piso = 3'd1; su = 4'b0010; subiendo = 1'b0;
    step(); chk("dir_no_open", estado, 2'b00);
    subiendo = 1'b1;
    step(); chk("dir_open", estado, 2'b11);
    su = '0;
    count_state(2'b11, n);
    chk("dir_limpiar_subir", lsub, 4'b0010);
    chk("dir_limpiar_bajar", lbaj, 4'b0000);
    count_state(2'b01, n);
    count_state(2'b10, n);
    subiendo = 1'b0;

    // Close button on the third open cycle, then sensor holding the door against it
    open_at_2();
    count_state(2'b11, n);
    step(); step();
    boton = 2'b10;
    step(); chk("btn_close", estado, 2'b10);
    boton = 2'b00;
    count_state(2'b10, n);
    open_at_2();
    count_state(2'b11, n);
    sensor = 1'b1; boton = 2'b10;
    repeat (15) step();
    chk("sensor_holds", estado, 2'b01);
    sensor = 1'b0; boton = 2'b00;
    count_state(2'b01, n); chk("sensor_release_cycles", n, TA);

    // Reversal on the second closing cycle
    step();
    sensor = 1'b1;
    step(); chk("rev_estado", estado, 2'b11);
    sensor = 1'b0;
    count_state(2'b11, n); chk("rev_cycles", n, 2);
    chk("rev_abierta", estado, 2'b01);

    // Nudge after MAXR reopens; the next obstruction is ignored
    apply_reset();
    open_at_2();
    for (int r = 0; r < MAXR; r++) begin
      count_state(2'b11, n);
      count_state(2'b01, n);
      sensor = 1'b1;
      step();
      sensor = 1'b0;
      chk($sformatf("nudge_after_%0d", r + 1), nudge, (r + 1 >= MAXR) ? 1'b1 : 1'b0);
    end
    count_state(2'b11, n);
    count_state(2'b01, n);
    sensor = 1'b1;
    count_state(2'b10, n); chk("nudge_close_cycles", n, TM);
    chk("nudge_closed", estado, 2'b00);
    chk("nudge_cleared", nudge, 1'b0);
    sensor = 1'b0;

    // Asynchronous reset while open
    open_at_2();
    count_state(2'b11, n);
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("areset_estado", estado, 2'b00);
    chk("areset_salida", salida, 2'b00);
    chk("areset_trab", trab, 1'b0);
    chk("areset_pulses", {aviso, lcab, lsub, lbaj}, 16'h0);
    chk("areset_nudge", nudge, 1'b0);
    model_reset();
    reset = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      piso = PW'($urandom_range(0, 5));
      moviendo = ($urandom_range(0, 3) == 0);
      subiendo = $urandom_range(0, 1) == 1;
      sensor = ($urandom_range(0, 14) == 0);
      for (int p = 0; p < NP; p++) begin
        cab[p] = ($urandom_range(0, 15) == 0);
        su[p] = ($urandom_range(0, 15) == 0);
        ba[p] = ($urandom_range(0, 15) == 0);
      end
      r = $urandom_range(0, 19);
      boton = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
